// File: rtl/hartslag_meter_pkg.sv
// Shared types and constants for the heart-rate meter.
// BPM_NUMERATOR assumes a 1 ms measurement tick (60000 ms per minute).
package hartslag_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    DIVIDE     = 2'd2
  } state_e;

  localparam logic [15:0] BPM_NUMERATOR = 16'd60000;
  localparam int          BPM_W         = 8;

  function automatic logic [BPM_W-1:0] sat_bpm(input logic [15:0] quot);
    if (quot > 16'((1 << BPM_W) - 1)) begin
      return {BPM_W{1'b1}};
    end
    return quot[BPM_W-1:0];
  endfunction

endpackage

// File: rtl/hartslag_meter_seq_divider_16.sv
// seq_divider_16: unsigned restoring divider, one quotient bit per clock.
// The first bit is produced on the start cycle; done_o pulses after the 16th.
module seq_divider_16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic        done_o,
  output logic [15:0] quotient_o
);

  logic [15:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // quo holds the unconsumed dividend bits in its top and collects quotient bits at the bottom
  function automatic logic [31:0] div_step(input logic [15:0] rem,
                                           input logic [15:0] quo,
                                           input logic [15:0] dvs);
    logic [16:0] r;
    r = {rem, quo[15]};
    if (r >= {1'b0, dvs}) begin
      r = r - {1'b0, dvs};
      return {r[15:0], quo[14:0], 1'b1};
    end
    return {r[15:0], quo[14:0], 1'b0};
  endfunction

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      {rem_d, quo_d} = div_step(16'd0, dividend_i, divisor_i);
      div_d  = divisor_i;
      cnt_d  = 4'd15;
      busy_d = 1'b1;
    end else if (busy_q) begin
      {rem_d, quo_d} = div_step(rem_q, quo_q, div_q);
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/hartslag_meter.sv
// hartslag_meter: synchronise, debounce and edge-detect the heart-pulse input,
// measure the beat period in ticks and convert it to BPM with a sequential divider.
module hartslag_meter
  import hartslag_meter_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 5,
  parameter int MIN_PERIOD     = 250,
  parameter int MAX_PERIOD     = 3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hartslagIngang,
  output logic [BPM_W-1:0] hartslag,
  output logic             hartslag_valid,
  output logic             hartslag_lock
);

  localparam int PRESC_DIV = CLK_HZ / TICK_HZ;
  localparam int PW        = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int DW        = $clog2(DEBOUNCE_TICKS + 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             beat_q, beat_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  state_e           state_q, state_d;
  logic [15:0]      period_q, period_d;
  logic [BPM_W-1:0] bpm_q, bpm_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             div_start, div_done;
  logic [15:0]      div_quot;

  assign tick    = (presc_q == PW'(PRESC_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // beat_q rises together with the debounced level
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    beat_d    = 1'b0;
    if (tick) begin
      if (sync2_q == deb_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
        deb_d     = sync2_q;
        deb_cnt_d = '0;
        beat_d    = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    bpm_d     = bpm_q;
    valid_d   = 1'b0;
    lock_d    = lock_q;
    div_start = 1'b0;
    if (tick && (period_q != 16'(MAX_PERIOD))) begin
      period_d = period_q + 16'd1;
    end
    case (state_q)
      WAIT_FIRST: begin
        if (beat_q) begin
          period_d = '0;
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        if (period_q >= 16'(MAX_PERIOD)) begin
          bpm_d   = '0;
          valid_d = 1'b1;
          lock_d  = 1'b0;
          state_d = WAIT_FIRST;
        end else if (beat_q && (period_q >= 16'(MIN_PERIOD))) begin
          period_d  = '0;
          div_start = 1'b1;
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) begin
          bpm_d   = sat_bpm(div_quot);
          valid_d = 1'b1;
          lock_d  = 1'b1;
          state_d = MEASURE;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      beat_q    <= 1'b0;
      state_q   <= WAIT_FIRST;
      period_q  <= '0;
      bpm_q     <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      sync1_q   <= hartslagIngang;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      beat_q    <= beat_d;
      state_q   <= state_d;
      period_q  <= period_d;
      bpm_q     <= bpm_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
    end
  end

  seq_divider_16 u_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .start_i    (div_start),
    .dividend_i (BPM_NUMERATOR),
    .divisor_i  (period_q),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  assign hartslag       = bpm_q;
  assign hartslag_valid = valid_q;
  assign hartslag_lock  = lock_q;

endmodule
